// File: rtl/prefixadd_pkg.sv
// Shared types and elaboration-time helpers for the pipelined prefix adder.
package prefixadd_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LPS   = 1;

    // Generate/propagate pair for one bit (or one bit-group after combining).
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Ceiling log2, valid for v >= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    // Number of prefix stages after the input register.
    function automatic int num_stages(input int width, input int lps);
        int l;
        l = clog2(width);
        return (l + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/prefix_level.sv
// One Sklansky combining level: every bit whose LEVEL-th index bit is set
// absorbs the group ending just below its 2^LEVEL-aligned block.
module prefix_level
    import prefixadd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEVEL = 0
) (
    input  gp_t [WIDTH-1:0] i_gp,
    output gp_t [WIDTH-1:0] o_gp
);

    localparam int SPAN = 1 << LEVEL;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i / SPAN) % 2) == 1) begin : g_comb
            localparam int J = (i / SPAN) * SPAN - 1;
            assign o_gp[i].g = i_gp[i].g | (i_gp[i].p & i_gp[J].g);
            assign o_gp[i].p = i_gp[i].p & i_gp[J].p;
        end else begin : g_pass
            assign o_gp[i] = i_gp[i];
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Sklansky add/subtract with carry-in, carry-out and signed
// overflow. Global-stall valid/ready pipeline: every register holds while
// the output is valid and not accepted.
module pipelined_prefix_adder
    import prefixadd_pkg::*;
#(
    parameter int WIDTH            = DEF_WIDTH,
    parameter int LEVELS_PER_STAGE = DEF_LPS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L = clog2(WIDTH);

    logic             w_advance;
    logic             r_vld_p0;
    logic [WIDTH-1:0] r_a_p0;
    logic [WIDTH-1:0] r_b_p0;
    logic             r_c0_p0;
    gp_t  [WIDTH-1:0] w_gp_p0;

    logic [WIDTH-1:0] w_gfin;
    logic [WIDTH-1:0] w_unused_pfin;
    logic [WIDTH-1:0] w_carry;

    logic             r_out_vld;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign w_advance = !r_out_vld || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_vld;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // ---- Stage 0: operand capture (subtract folds into ~b and carry-in 1)
    // Input valid: loads on every advance, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_vld_p0 <= 1'b0;
        else if (w_advance) r_vld_p0 <= in_valid;
    end

    // Input operands: effective B and carry-in already resolved for sub.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_a_p0  <= a;
            r_b_p0  <= sub ? ~b : b;
            r_c0_p0 <= sub | cin;
        end
    end

    // Bitwise G/P; bit 0 absorbs the carry-in so the tree yields G(i:-1).
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_gp_p0[i].g = r_a_p0[i] & r_b_p0[i];
            w_gp_p0[i].p = r_a_p0[i] ^ r_b_p0[i];
        end
        w_gp_p0[0].g = (r_a_p0[0] & r_b_p0[0]) | ((r_a_p0[0] ^ r_b_p0[0]) & r_c0_p0);
        w_gp_p0[0].p = 1'b0;
    end

    // ---- Stages 1..S: prefix levels, registered every LEVELS_PER_STAGE
    for (genvar l = 0; l < L; l++) begin : g_lvl
        gp_t  [WIDTH-1:0] w_gp_in;
        gp_t  [WIDTH-1:0] w_gp_lvl;
        gp_t  [WIDTH-1:0] w_gp_nxt;
        logic [WIDTH-1:0] w_pc_in;
        logic [WIDTH-1:0] w_pc_nxt;
        logic             w_c0_in;
        logic             w_c0_nxt;
        logic             w_vld_in;
        logic             w_vld_nxt;

        if (l == 0) begin : g_src
            assign w_gp_in  = w_gp_p0;
            assign w_pc_in  = r_a_p0 ^ r_b_p0;
            assign w_c0_in  = r_c0_p0;
            assign w_vld_in = r_vld_p0;
        end else begin : g_src
            assign w_gp_in  = g_lvl[l-1].w_gp_nxt;
            assign w_pc_in  = g_lvl[l-1].w_pc_nxt;
            assign w_c0_in  = g_lvl[l-1].w_c0_nxt;
            assign w_vld_in = g_lvl[l-1].w_vld_nxt;
        end

        prefix_level #(
            .WIDTH (WIDTH),
            .LEVEL (l)
        ) u_level (
            .i_gp (w_gp_in),
            .o_gp (w_gp_lvl)
        );

        // The last stage's register is the output register below.
        if ((((l + 1) % LEVELS_PER_STAGE) == 0) && ((l + 1) < L)) begin : g_stage
            gp_t  [WIDTH-1:0] r_gp;
            logic [WIDTH-1:0] r_pc;
            logic             r_c0;
            logic             r_vld;

            // Stage valid: shifts on advance, cleared by reset.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) r_vld <= 1'b0;
                else if (w_advance) r_vld <= w_vld_in;
            end

            // Stage data: partial prefix state plus the untouched P copy.
            always_ff @(posedge clk) begin
                if (w_advance) begin
                    r_gp <= w_gp_lvl;
                    r_pc <= w_pc_in;
                    r_c0 <= w_c0_in;
                end
            end

            assign w_gp_nxt  = r_gp;
            assign w_pc_nxt  = r_pc;
            assign w_c0_nxt  = r_c0;
            assign w_vld_nxt = r_vld;
        end else begin : g_stage
            assign w_gp_nxt  = w_gp_lvl;
            assign w_pc_nxt  = w_pc_in;
            assign w_c0_nxt  = w_c0_in;
            assign w_vld_nxt = w_vld_in;
        end
    end

    // ---- Final: carries from group generates, result onto outputs
    // Split the finished tree into group generates; group propagates are spent.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_gfin[i]        = g_lvl[L-1].w_gp_nxt[i].g;
            w_unused_pfin[i] = g_lvl[L-1].w_gp_nxt[i].p;
        end
    end

    assign w_carry = {w_gfin[WIDTH-2:0], g_lvl[L-1].w_c0_nxt};

    // Output register: result loads only with a valid op; all clear on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_vld <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_advance) begin
            r_out_vld <= g_lvl[L-1].w_vld_nxt;
            if (g_lvl[L-1].w_vld_nxt) begin
                r_sum  <= g_lvl[L-1].w_pc_nxt ^ w_carry;
                r_cout <= w_gfin[WIDTH-1];
                r_ovf  <= w_gfin[WIDTH-1] ^ w_gfin[WIDTH-2];
            end
        end
    end

endmodule
